// File: rtl/alu_mc_pkg.sv
// Shared opcode, slice-operation and FSM definitions for the multi-cycle ALU.
// The classification helpers decide which flags an opcode is allowed to report.
package alu_mc_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    localparam logic [1:0] SL_AND  = 2'b00;
    localparam logic [1:0] SL_OR   = 2'b01;
    localparam logic [1:0] SL_ADD  = 2'b10;
    localparam logic [1:0] SL_LESS = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic logic op_is_single(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_has_carry(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_has_ovf(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU cell: optional operand inversion, AND/OR/full-add/less select.
// 'set' exposes the raw sum so the chain can be reused as a plain adder.
module alu_bit_slice
    import alu_mc_pkg::*;
(
    input  logic       src1,
    input  logic       src2,
    input  logic       less,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout,
    output logic       set
);

    logic w_a;
    logic w_b;

    assign w_a  = src1 ^ a_invert;
    assign w_b  = src2 ^ b_invert;
    assign set  = w_a ^ w_b ^ cin;
    assign cout = (w_a & w_b) | (w_a & cin) | (w_b & cin);

    // Operation select for the cell output
    always_comb begin
        result = 1'b0;
        case (operation)
            SL_AND:  result = w_a & w_b;
            SL_OR:   result = w_a | w_b;
            SL_ADD:  result = set;
            SL_LESS: result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: slice-chain datapath shared between single-cycle ops and an
// iterative shift-add multiplier, with valid/ready handshakes and a registered result.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [3:0]       w_ctrl;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_set;
    logic             w_msb_cin;
    logic             w_msb_cout;
    logic             w_ovf_raw;
    logic             w_less;
    logic [WIDTH-1:0] w_prod_nxt;
    logic             w_accept;
    logic             w_start_mul;
    logic             w_load;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_cout_nxt;
    logic             w_ovf_nxt;

    assign in_ready  = (r_state == ST_IDLE) && !r_out_valid;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign busy      = (r_state == ST_MUL);

    // While multiplying, the slice chain is borrowed as the accumulator adder
    always_comb begin
        if (r_state == ST_MUL) begin
            w_a    = r_prod;
            w_b    = r_mcand;
            w_ctrl = OP_ADD;
        end else begin
            w_a    = src1;
            w_b    = src2;
            w_ctrl = alu_ctrl;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic w_ci;
        logic w_co;
        logic w_lss;
        if (i == 0) begin : g_lsb
            assign w_ci  = w_ctrl[2];
            assign w_lss = w_less;
        end else begin : g_upper
            assign w_ci  = g_slice[i-1].w_co;
            assign w_lss = 1'b0;
        end
        alu_bit_slice u_slice (
            .src1      (w_a[i]),
            .src2      (w_b[i]),
            .less      (w_lss),
            .a_invert  (w_ctrl[3]),
            .b_invert  (w_ctrl[2]),
            .cin       (w_ci),
            .operation (w_ctrl[1:0]),
            .result    (w_res[i]),
            .cout      (w_co),
            .set       (w_set[i])
        );
    end

    assign w_msb_cin  = g_slice[WIDTH-1].w_ci;
    assign w_msb_cout = g_slice[WIDTH-1].w_co;
    assign w_ovf_raw  = w_msb_cin ^ w_msb_cout;
    // Signed less-than: MSB sum corrected by overflow
    assign w_less     = w_set[WIDTH-1] ^ w_ovf_raw;
    assign w_prod_nxt = r_mplier[0] ? w_set : r_prod;

    // Next-state and output-register load decisions
    always_comb begin
        w_state_nxt = r_state;
        w_start_mul = 1'b0;
        w_load      = 1'b0;
        w_res_nxt   = '0;
        w_cout_nxt  = 1'b0;
        w_ovf_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (alu_ctrl == OP_MUL) begin
                        w_start_mul = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_load = 1'b1;
                        if (op_is_single(alu_ctrl)) begin
                            w_res_nxt  = w_res;
                            w_cout_nxt = op_has_carry(alu_ctrl) ? w_msb_cout : 1'b0;
                            w_ovf_nxt  = op_has_ovf(alu_ctrl) ? w_ovf_raw : 1'b0;
                        end else begin
                            w_res_nxt = '0;
                        end
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_load      = 1'b1;
                    w_res_nxt   = w_prod_nxt;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_MUL;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Multiplier operand, partial product and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (w_start_mul) begin
            r_mcand  <= src1;
            r_mplier <= src2;
            r_prod   <= '0;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (r_state == ST_MUL) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= w_prod_nxt;
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    // Output register: loads on completion, holds until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_result    <= w_res_nxt;
            r_zero      <= (w_res_nxt == '0);
            r_cout      <= w_cout_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): directed vectors, randomized ops
// against an arithmetic reference model, backpressure and mid-multiply reset.
module tb_alu_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] src1 = 8'h00;
    logic [7:0] src2 = 8'h00;
    logic [3:0] alu_ctrl = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       zero;
    logic       cout;
    logic       overflow;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mc #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain two's-complement arithmetic on the operands
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output logic v);
        logic [8:0]  s;
        logic [15:0] p;
        r = 8'h00; c = 1'b0; v = 1'b0;
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b1101: r = ~(a & b);
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'b0110: begin
                r = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'b0111: begin
                c = s[8];
                r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            end
            4'b1000: begin
                p = a * b;
                r = p[7:0];
            end
            default: r = 8'h00;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; alu_ctrl = op; src1 = a; src2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_tests++; if ({out_valid, result, zero, cout, overflow, busy} !== 13'h0) begin n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, result, zero, cout, overflow, busy}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    typedef struct { logic [3:0] op; logic [7:0] a, b, r; logic z, c, v; int lat; } vec_t;

    task automatic test_directed;
        vec_t vt [9] = '{
            '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1},
            '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1},
            '{4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1},
            '{4'b0111, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1},
            '{4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1},
            '{4'b1101, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1},
            '{4'b1111, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1},
            '{4'b1000, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 9},
            '{4'b1000, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 9}
        };
        int lat;
        foreach (vt[i]) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, lat);
            n_tests++; if (lat !== vt[i].lat || result !== vt[i].r || {zero, cout, overflow} !== {vt[i].z, vt[i].c, vt[i].v}) begin
                n_fail++;
                $display("FAIL directed_%0d op=%b: got lat=%0d r=%h zcv=%b%b%b expected lat=%0d r=%h zcv=%b%b%b",
                         i, vt[i].op, lat, result, zero, cout, overflow, vt[i].lat, vt[i].r, vt[i].z, vt[i].c, vt[i].v);
            end
            consume();
        end
    endtask

    task automatic test_mul_busy;
        int busy_cycles = 0;
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; alu_ctrl = 4'b1000; src1 = 8'h0D; src2 = 8'h0B;
        @(posedge clk); #1; in_valid = 1'b0;
        while (busy && busy_cycles < 40) begin
            n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++;
                $display("FAIL mul_busy_hold: got out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready); end
            @(posedge clk); #1; busy_cycles++;
        end
        n_tests++; if (busy_cycles !== 8 || out_valid !== 1'b1 || result !== 8'h8F) begin n_fail++;
            $display("FAIL mul_busy_count: got busy=%0d ov=%b r=%h expected 8 1 8f", busy_cycles, out_valid, result); end
        consume();
    endtask

    task automatic test_random;
        logic [3:0] ops [13] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101,
                                 4'b1000, 4'b0011, 4'b0100, 4'b1001, 4'b1110, 4'b1111};
        logic [3:0] op;
        logic [7:0] a, b, er;
        logic       ec, ev;
        int         lat, elat;
        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 12)];
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (k % 7 == 0) b = a;
            model(op, a, b, er, ec, ev);
            elat = (op == 4'b1000) ? 9 : 1;
            do_op(op, a, b, lat);
            n_tests++; if (lat !== elat || result !== er || zero !== (er == 8'h00) || cout !== ec || overflow !== ev) begin
                n_fail++;
                $display("FAIL random op=%b a=%h b=%h: got lat=%0d r=%h z=%b c=%b v=%b expected lat=%0d r=%h z=%b c=%b v=%b",
                         op, a, b, lat, result, zero, cout, overflow, elat, er, (er == 8'h00), ec, ev);
            end
            consume();
            n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
                $display("FAIL random_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        do_op(4'b0010, 8'h12, 8'h34, lat);
        in_valid = 1'b1; alu_ctrl = 4'b0110; src1 = 8'h50; src2 = 8'h20;
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (out_valid !== 1'b1 || result !== 8'h46 || in_ready !== 1'b0) begin n_fail++;
                $display("FAIL bp_hold_%0d: got ov=%b r=%h ir=%b expected 1 46 0", k, out_valid, result, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_release: got ov=%b ir=%b expected 0 1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || result !== 8'h30 || cout !== 1'b1) begin n_fail++;
            $display("FAIL bp_second: got ov=%b r=%h c=%b expected 1 30 1", out_valid, result, cout); end
        consume();
    endtask

    task automatic test_reset_mid_mul;
        int lat;
        in_valid = 1'b1; alu_ctrl = 4'b1000; src1 = 8'h0D; src2 = 8'h0B;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 8'h00) begin n_fail++;
            $display("FAIL rst_mid_mul: got ov=%b busy=%b r=%h expected 0 0 00", out_valid, busy, result); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(4'b0010, 8'h21, 8'h43, lat);
        n_tests++; if (lat !== 1 || result !== 8'h64 || busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_then_add: got lat=%0d r=%h busy=%b expected 1 64 0", lat, result, busy); end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul_busy();
        test_random();
        test_backpressure();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
